// File: rtl/hls_deadlock_monitor_multi_pkg.sv
// Shared types and helpers for the HLS deadlock monitor.
package hls_deadlock_monitor_multi_pkg;

    // Monitor state: quiet, counting a persistent blocking condition, latched deadlock.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SUSPECT  = 2'd1,
        ST_DEADLOCK = 2'd2
    } dl_state_e;

    // Index width for an n-entry vector. Never less than one bit, so n = 1 still has a port.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hls_deadlock_monitor_multi_prio_enc.sv
// Lowest-set-bit priority encoder. It reports which monitored channel is the first blocker.
module deadlock_prio_enc
    import hls_deadlock_monitor_multi_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // Scan from the top down so that the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        vld = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/hls_deadlock_monitor_multi.sv
// Deadlock monitor for an HLS top level that has several AXIS channels and parallel sub-instances.
// A blocking condition must persist for eff_thr consecutive cycles before the sticky flag
// 'block' rises. On entry the monitor snapshots the offending channels and instances.
// 'clear' releases the flag and the snapshots. 'reset' also zeroes the event counter.
module hls_deadlock_monitor_multi
    import hls_deadlock_monitor_multi_pkg::*;
#(
    parameter int NUM_AXIS = 4,
    parameter int NUM_INST = 4,
    parameter int THRESH_W = 16,
    parameter int CNT_W    = 8
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [THRESH_W-1:0]                 cfg_threshold,
    input  logic [NUM_AXIS-1:0]                 axis_mask,
    input  logic                                clear,
    input  logic [NUM_AXIS-1:0]                 axis_block_sigs,
    input  logic [NUM_INST-1:0]                 inst_idle_sigs,
    input  logic [NUM_INST-1:0]                 inst_block_sigs,
    output logic                                block,
    output logic                                block_pulse,
    output logic [NUM_AXIS-1:0]                 block_axis_snap,
    output logic [NUM_INST-1:0]                 block_inst_snap,
    output logic [clog2_min1(NUM_AXIS)-1:0]     first_axis_idx,
    output logic                                first_axis_vld,
    output logic [CNT_W-1:0]                    event_count
);

    localparam int AXIS_IDX_W = clog2_min1(NUM_AXIS);

    // The state and persistence count are named signals so that checkers can probe them.
    dl_state_e           state;
    dl_state_e           next_state;
    logic [THRESH_W-1:0] cnt;
    logic [THRESH_W-1:0] cnt_next;

    logic [NUM_AXIS-1:0]   axis_masked;
    logic                  axis_hit;
    logic                  par_hit;
    logic                  cond;
    logic [THRESH_W-1:0]   eff_thr;
    logic [THRESH_W-1:0]   cnt_sat_inc;
    logic                  reach;
    logic                  enter;
    logic [AXIS_IDX_W-1:0] enc_idx;
    logic                  enc_vld;

    // Blocking condition. It is live every cycle, and the threshold takes effect as soon as it changes.
    always_comb begin
        axis_masked = axis_block_sigs & axis_mask;
        axis_hit    = |axis_masked;
        par_hit     = (&(inst_block_sigs | inst_idle_sigs)) & (|inst_block_sigs);
        cond        = axis_hit | par_hit;
        eff_thr     = (cfg_threshold == '0) ? THRESH_W'(1) : cfg_threshold;
        // The count saturates rather than wrapping. Once saturated it forces entry, so a
        // threshold beyond the reachable count still results in a deadlock.
        cnt_sat_inc = (cnt == '1) ? cnt : cnt + THRESH_W'(1);
        reach       = ({1'b0, cnt} + {{THRESH_W{1'b0}}, 1'b1} >= {1'b0, eff_thr}) || (cnt == '1);
    end

    deadlock_prio_enc #(
        .N     (NUM_AXIS),
        .IDX_W (AXIS_IDX_W)
    ) u_prio_enc (
        .vec (axis_masked),
        .idx (enc_idx),
        .vld (enc_vld)
    );

    // State register and persistence counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. clear overrides everything, including a same-cycle entry.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        if (clear) begin
            next_state = ST_IDLE;
            cnt_next   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cnt_next = '0;
                    if (cond) begin
                        cnt_next   = THRESH_W'(1);
                        next_state = (eff_thr == THRESH_W'(1)) ? ST_DEADLOCK : ST_SUSPECT;
                    end
                end
                ST_SUSPECT: begin
                    if (!cond) begin
                        next_state = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_sat_inc;
                        if (reach) begin
                            next_state = ST_DEADLOCK;
                        end
                    end
                end
                ST_DEADLOCK: begin
                    next_state = ST_DEADLOCK;
                end
                default: begin
                    next_state = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Output decode: entry is the single cycle in which the FSM is about to move into DEADLOCK.
    always_comb begin
        enter = (state != ST_DEADLOCK) && (next_state == ST_DEADLOCK);
    end

    // Registered flag, pulse, snapshots and saturating event counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            block           <= 1'b0;
            block_pulse     <= 1'b0;
            block_axis_snap <= '0;
            block_inst_snap <= '0;
            first_axis_idx  <= '0;
            first_axis_vld  <= 1'b0;
            event_count     <= '0;
        end else if (clear) begin
            block           <= 1'b0;
            block_pulse     <= 1'b0;
            block_axis_snap <= '0;
            block_inst_snap <= '0;
            first_axis_idx  <= '0;
            first_axis_vld  <= 1'b0;
        end else begin
            block_pulse <= enter;
            if (enter) begin
                block           <= 1'b1;
                block_axis_snap <= axis_masked;
                block_inst_snap <= inst_block_sigs;
                first_axis_idx  <= enc_idx;
                first_axis_vld  <= enc_vld;
                if (event_count != '1) begin
                    event_count <= event_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
